// File: rtl/hopfield_synapse_scheduler.sv
// ============================================================================
// hopfield_synapse_scheduler
//   Per-row weight fetch and accumulation of Hopfield synaptic currents.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hopfield_synapse_scheduler #(
  parameter int N   = 7,
  parameter int WW  = 16,
  parameter int CW  = 32,
  parameter int PIN = 4,
  parameter int INJ = 131072,
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N-1:0]         spikes,
  input  logic                 learning_enable,
  input  logic [PIN-1:0]       pattern_input,
  output logic                 w_req,
  output logic [AW-1:0]        w_row,
  output logic [AW-1:0]        w_col,
  input  logic                 w_ack,
  input  logic signed [WW-1:0] w_data,
  output logic                 cur_valid,
  output logic [AW-1:0]        cur_idx,
  output logic signed [CW-1:0] cur_data,
  output logic                 busy,
  output logic                 done
);

  localparam logic signed [CW-1:0] INJ_C = CW'(INJ);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REQ, S_EMIT} state_t;

  state_t                state_q;
  logic [N-1:0]          spk_q;
  logic                  lrn_q;
  logic [PIN-1:0]        pat_q;
  logic [AW-1:0]         row_q, col_q;
  logic signed [CW-1:0]  acc_q;
  logic                  w_req_q, cur_valid_q, busy_q, done_q;
  logic [AW-1:0]         w_row_q, w_col_q, cur_idx_q;
  logic signed [CW-1:0]  cur_data_q;

  logic [N-1:0]          inj_mask_d;
  logic signed [CW-1:0]  wext_d, inj_d, emit_sum_d;
  logic                  last_col_d, last_row_d, skip_d;

  // Only neurons below PIN have a pattern input bit.
  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_inj
    if (gi < PIN) begin : g_on
      assign inj_mask_d[gi] = pat_q[gi];
    end else begin : g_off
      assign inj_mask_d[gi] = 1'b0;
    end
  end

  assign wext_d     = CW'(w_data) <<< 8;
  assign inj_d      = (lrn_q && inj_mask_d[row_q]) ? INJ_C : '0;
  assign emit_sum_d = acc_q + inj_d;
  assign last_col_d = (col_q == AW'(N - 1));
  assign last_row_d = (row_q == AW'(N - 1));
  assign skip_d     = (col_q == row_q) || !spk_q[col_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      spk_q       <= '0;
      lrn_q       <= 1'b0;
      pat_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      w_req_q     <= 1'b0;
      w_row_q     <= '0;
      w_col_q     <= '0;
      cur_valid_q <= 1'b0;
      cur_idx_q   <= '0;
      cur_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cur_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          // busy is still high for the cycle after done, so start is refused there.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            spk_q   <= spikes;
            lrn_q   <= learning_enable;
            pat_q   <= pattern_input;
            acc_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (skip_d) begin
            if (last_col_d) state_q <= S_EMIT;
            else            col_q   <= col_q + AW'(1);
          end else begin
            w_req_q <= 1'b1;
            w_row_q <= row_q;
            w_col_q <= col_q;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            acc_q   <= acc_q + wext_d;
            w_req_q <= 1'b0;
            if (last_col_d) begin
              state_q <= S_EMIT;
            end else begin
              col_q   <= col_q + AW'(1);
              state_q <= S_SCAN;
            end
          end
        end
        S_EMIT: begin
          cur_valid_q <= 1'b1;
          cur_idx_q   <= row_q;
          cur_data_q  <= emit_sum_d;
          acc_q       <= '0;
          col_q       <= '0;
          if (last_row_d) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            row_q   <= row_q + AW'(1);
            state_q <= S_SCAN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign w_req     = w_req_q;
  assign w_row     = w_row_q;
  assign w_col     = w_col_q;
  assign cur_valid = cur_valid_q;
  assign cur_idx   = cur_idx_q;
  assign cur_data  = cur_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hopfield_synapse_scheduler.sv
// ============================================================================
// tb_hopfield_synapse_scheduler
//   Randomized self-checking bench with a sum-of-weights reference model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hopfield_synapse_scheduler;

  localparam int N   = 7;
  localparam int WW  = 16;
  localparam int CW  = 32;
  localparam int PIN = 4;
  localparam int INJ = 131072;
  localparam int AW  = 3;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [N-1:0]         spikes;
  logic                 learning_enable;
  logic [PIN-1:0]       pattern_input;
  logic                 w_req;
  logic [AW-1:0]        w_row, w_col;
  logic                 w_ack;
  logic signed [WW-1:0] w_data;
  logic                 cur_valid;
  logic [AW-1:0]        cur_idx;
  logic signed [CW-1:0] cur_data;
  logic                 busy, done;

  hopfield_synapse_scheduler #(
    .N(N), .WW(WW), .CW(CW), .PIN(PIN), .INJ(INJ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .spikes(spikes),
    .learning_enable(learning_enable), .pattern_input(pattern_input),
    .w_req(w_req), .w_row(w_row), .w_col(w_col), .w_ack(w_ack), .w_data(w_data),
    .cur_valid(cur_valid), .cur_idx(cur_idx), .cur_data(cur_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic signed [WW-1:0] w_mem [N][N];
  logic signed [CW-1:0] exp_cur [N];
  logic signed [CW-1:0] got_cur [N];
  int                   exp_fetch;
  logic [N-1:0]         snap_spk;
  int                   min_dly, max_dly;
  int                   extra;
  int                   n_fetch;

  // Weight memory responder; also throws spurious acks while no request is open.
  initial begin : responder
    int cnt, dly;
    logic [AW-1:0] lr, lc;
    bit inreq;
    w_ack = 1'b0; w_data = '0; cnt = 0; dly = 0; inreq = 0; lr = '0; lc = '0;
    forever begin
      @(negedge clk);
      if (w_req) begin
        if (!inreq) begin
          inreq = 1;
          lr = w_row;
          lc = w_col;
          dly = $urandom_range(max_dly, min_dly);
          n_fetch++;
          chk("fetch_not_diag", longint'(w_row != w_col), 1);
          chk("fetch_col_spiking", longint'(snap_spk[w_col]), 1);
        end else begin
          chk("w_row_hold", w_row, lr);
          chk("w_col_hold", w_col, lc);
        end
        if (cnt >= dly) begin
          w_ack = 1'b1;
          w_data = w_mem[w_row][w_col];
          extra += dly + 1;
          cnt = 0;
          inreq = 0;
        end else begin
          w_ack = 1'b0;
          cnt++;
        end
      end else begin
        inreq = 0;
        cnt = 0;
        w_ack = ($urandom_range(3, 0) == 0);
        w_data = WW'($urandom);
      end
    end
  end

  task automatic fill_mem(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (mode)
          0:       w_mem[i][j] = WW'($urandom);
          1:       w_mem[i][j] = WW'(16 * i + j);
          default: w_mem[i][j] = -16'sd32768;
        endcase
  endtask

  task automatic model(input logic [N-1:0] spk, input bit lrn, input logic [PIN-1:0] pat);
    logic signed [CW-1:0] s;
    exp_fetch = 0;
    for (int i = 0; i < N; i++) begin
      s = '0;
      for (int j = 0; j < N; j++)
        if (j != i && spk[j]) begin
          s = s + CW'(w_mem[i][j]) * 256;
          exp_fetch++;
        end
      if (lrn && i < PIN && pat[i]) s = s + INJ;
      exp_cur[i] = s;
    end
  endtask

  task automatic run_sweep(input logic [N-1:0] spk, input bit lrn,
                           input logic [PIN-1:0] pat, input bit poke_start);
    int r, done_m;
    model(spk, lrn, pat);
    snap_spk = spk;
    extra = 0;
    n_fetch = 0;
    @(negedge clk);
    spikes = spk; learning_enable = lrn; pattern_input = pat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    spikes = N'($urandom); learning_enable = 1'($urandom); pattern_input = PIN'($urandom);
    r = 0;
    done_m = -1;
    for (int m = 0; m < 4000 && done_m < 0; m++) begin
      if (m > 0) @(negedge clk);
      if (poke_start) start = (m == 20 || m == 21);
      if (cur_valid) begin
        if (r < N) begin
          chk("cur_idx", cur_idx, r);
          chk("cur_data", cur_data, exp_cur[r]);
          got_cur[r] = cur_data;
        end
        chk("cur_valid_cycle", m, 8 * (r + 1) + extra);
        chk("busy_at_emit", busy, 1);
        r++;
      end
      if (done) begin
        chk("done_with_last", r, N);
        done_m = m;
      end
    end
    start = 1'b0;
    if (done_m < 0) begin
      chk("sweep_timeout", 0, 1);
    end else begin
      chk("fetch_count", n_fetch, exp_fetch);
      @(negedge clk);
      chk("busy_drop", busy, 0);
      chk("done_drop", done, 0);
      chk("cur_valid_drop", cur_valid, 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_w_req"}, w_req, 0);
    chk({tag, "_cur_valid"}, cur_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_w_row"}, w_row, 0);
    chk({tag, "_w_col"}, w_col, 0);
    chk({tag, "_cur_idx"}, cur_idx, 0);
    chk({tag, "_cur_data"}, cur_data, 0);
  endtask

  task automatic reset_mid_sweep();
    int seen;
    fill_mem(0);
    snap_spk = '1;
    min_dly = 0; max_dly = 2;
    @(negedge clk);
    spikes = '1; learning_enable = 1'b1; pattern_input = '1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int m = 0; m < 2000 && seen < 3; m++) begin
      @(negedge clk);
      if (cur_valid) seen++;
    end
    chk("reached_row3", seen, 3);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_done_in_reset", done, 0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
    end
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; spikes = '0; learning_enable = 1'b0; pattern_input = '0;
    min_dly = 0; max_dly = 0; extra = 0; n_fetch = 0; snap_spk = '0;
    fill_mem(0);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // No pattern: seven zero currents, no fetches.
    run_sweep('0, 1'b0, '0, 1'b0);
    chk("no_pattern_fetches", n_fetch, 0);

    // Injection only.
    run_sweep('0, 1'b1, 4'b1011, 1'b0);
    chk("inj_idx0", got_cur[0], 131072);
    chk("inj_idx2", got_cur[2], 0);
    chk("inj_idx3", got_cur[3], 131072);

    // Addressed weights, immediate ack.
    fill_mem(1);
    run_sweep(7'b0000011, 1'b0, '0, 1'b0);
    chk("addr_idx0", got_cur[0], 256);
    chk("addr_idx1", got_cur[1], 4096);
    chk("addr_idx2", got_cur[2], 16640);

    // Most negative weights with a three-cycle ack delay.
    fill_mem(2);
    min_dly = 3; max_dly = 3;
    run_sweep('1, 1'b0, '0, 1'b0);
    chk("neg_idx4", got_cur[4], -50331648);
    chk("neg_fetch_total", n_fetch, 42);

    // Start re-asserted mid-sweep.
    fill_mem(0);
    min_dly = 0; max_dly = 2;
    run_sweep(N'($urandom), 1'($urandom), PIN'($urandom), 1'b1);

    reset_mid_sweep();
    min_dly = 0; max_dly = 1;
    run_sweep(N'($urandom), 1'b1, PIN'($urandom), 1'b0);

    for (int t = 0; t < 6; t++) begin
      fill_mem(0);
      min_dly = 0;
      max_dly = $urandom_range(2, 0);
      run_sweep(N'($urandom), 1'($urandom), PIN'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
